// File: rtl/au_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Helpers work on fixed maximum-size vectors so one package serves every WIDTH
// up to AuMaxWidth; callers zero-extend their operands and slice the result.
package au_pkg;

  localparam int unsigned ARCH_MASKED = 0;
  localparam int unsigned ARCH_DOUBLE = 1;

  localparam int unsigned AuMaxWidth = 6;
  localparam int unsigned AuMaxN     = 1 << AuMaxWidth;

  typedef logic [AuMaxN-1:0]     au_vec_t;
  typedef logic [AuMaxWidth-1:0] au_idx_t;

  typedef struct packed {
    logic    found;
    au_idx_t idx;
  } au_pick_t;

  // One-hot decode of a binary index.
  function automatic au_vec_t onehot(input au_idx_t idx);
    au_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Masked-request pick with unmasked fallback: lowest set bit at or above ptr,
  // otherwise lowest set bit overall. Only the low 2**idx_w request bits count.
  function automatic au_pick_t rr_pick(input au_vec_t req, input au_idx_t ptr,
                                       input au_idx_t idx_w);
    au_pick_t    masked;
    au_pick_t    any;
    int unsigned n;
    masked = '0;
    any    = '0;
    n      = 32'd1 << idx_w;
    for (int unsigned i = 0; i < AuMaxN; i++) begin
      if (i < n && req[i]) begin
        if (!any.found) begin
          any.found = 1'b1;
          any.idx   = au_idx_t'(i);
        end
        if (!masked.found && i >= 32'(ptr)) begin
          masked.found = 1'b1;
          masked.idx   = au_idx_t'(i);
        end
      end
    end
    return masked.found ? masked : any;
  endfunction

endpackage

// File: rtl/au_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// ARCH selects masked+fallback (ARCH_MASKED) or double-width rotate (ARCH_DOUBLE);
// both produce identical results.
module au_rr_pick
  import au_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned ARCH  = ARCH_MASKED
) (
  input  logic [2**WIDTH-1:0] req_i,
  input  logic [WIDTH-1:0]    ptr_i,
  output logic [WIDTH-1:0]    win_o,
  output logic                found_o
);

  localparam int unsigned N = 2**WIDTH;

  if (ARCH == ARCH_DOUBLE) begin : g_double
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    // Rotate req so ptr lands at bit 0, then find-first and rotate the index back.
    always_comb begin
      dbl     = {req_i, req_i} >> ptr_i;
      rot     = dbl[N-1:0];
      found_o = 1'b0;
      win_o   = '0;
      for (int unsigned k = 0; k < N; k++) begin
        if (!found_o && rot[k]) begin
          found_o = 1'b1;
          win_o   = ptr_i + WIDTH'(k);
        end
      end
    end

    logic unused_dbl;
    assign unused_dbl = ^dbl[2*N-1:N];
  end else begin : g_masked
    au_pick_t pick;

    // Masked search with fallback lives in the package so it can be shared.
    always_comb begin
      pick    = rr_pick(au_vec_t'(req_i), au_idx_t'(ptr_i), au_idx_t'(WIDTH));
      win_o   = pick.idx[WIDTH-1:0];
      found_o = pick.found;
    end

    logic unused_pick;
    assign unused_pick = ^pick;
  end

endmodule

// File: rtl/au_rr_arbiter.sv
// Round-robin arbiter over 2**WIDTH requesters with a registered binary grant
// and valid/ready output handshake. The priority pointer advances past each winner.
// Optional: define AU_RR_ARBITER_ONEHOT_EN to add a registered one-hot out_grant.
module au_rr_arbiter
  import au_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned ARCH  = ARCH_MASKED
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2**WIDTH-1:0] req,
  output logic [2**WIDTH-1:0] req_ack,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef AU_RR_ARBITER_ONEHOT_EN
  output logic [2**WIDTH-1:0] out_grant,
`endif
  output logic [WIDTH-1:0]    out_idx
);

  localparam int unsigned N = 2**WIDTH;

  logic [WIDTH-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] win;
  logic             found;
  logic             load;
  au_vec_t          win_oh;

  au_rr_pick #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .win_o   (win),
    .found_o (found)
  );

  // Next-state and capture strobe; req is ignored while the output is stalled.
  always_comb begin
    load    = !valid_q || out_ready;
    win_oh  = onehot(au_idx_t'(win));
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    req_ack = '0;
    if (load) begin
      if (found) begin
        idx_d   = win;
        valid_d = 1'b1;
        ptr_d   = win + WIDTH'(1);
        // Gated by rst_n so no requester sees an ack while state is held in reset.
        req_ack = rst_n ? win_oh[N-1:0] : '0;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Grant and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;

`ifdef AU_RR_ARBITER_ONEHOT_EN
  logic [N-1:0] grant_q, grant_d;

  // One-hot copy of the grant; zero whenever no grant is held.
  always_comb begin
    grant_d = grant_q;
    if (load) begin
      grant_d = found ? win_oh[N-1:0] : '0;
    end
  end

  // One-hot grant register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
    end else begin
      grant_q <= grant_d;
    end
  end

  assign out_grant = grant_q;
`endif

  logic unused_oh;
  assign unused_oh = ^win_oh;

endmodule

// File: tb/tb_au_rr_arbiter.sv
// Directed checks of au_rr_arbiter (both pick architectures side by side) plus
// a short randomised run against an independent round-robin model.
module tb_au_rr_arbiter;

  localparam int unsigned W = 3;
  localparam int unsigned N = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         out_ready;
  logic [N-1:0] ack0, ack1;
  logic         v0, v1;
  logic [W-1:0] idx0, idx1;
`ifdef AU_RR_ARBITER_ONEHOT_EN
  logic [N-1:0] g0, g1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  au_rr_arbiter #(.WIDTH(W), .ARCH(0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_ack   (ack0),
    .out_valid (v0),
    .out_ready (out_ready),
`ifdef AU_RR_ARBITER_ONEHOT_EN
    .out_grant (g0),
`endif
    .out_idx   (idx0)
  );

  au_rr_arbiter #(.WIDTH(W), .ARCH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_ack   (ack1),
    .out_valid (v1),
    .out_ready (out_ready),
`ifdef AU_RR_ARBITER_ONEHOT_EN
    .out_grant (g1),
`endif
    .out_idx   (idx1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ack(input string tag, input logic [N-1:0] e);
    chk({tag, "/ack_a0"}, 32'(ack0), 32'(e));
    chk({tag, "/ack_a1"}, 32'(ack1), 32'(e));
  endtask

  task automatic exp_out(input string tag, input logic v, input logic [W-1:0] i);
    chk({tag, "/valid_a0"}, 32'(v0), 32'(v));
    chk({tag, "/valid_a1"}, 32'(v1), 32'(v));
    chk({tag, "/idx_a0"}, 32'(idx0), 32'(i));
    chk({tag, "/idx_a1"}, 32'(idx1), 32'(i));
`ifdef AU_RR_ARBITER_ONEHOT_EN
    begin
      logic [N-1:0] eg;
      eg = v ? (N'(1) << i) : '0;
      chk({tag, "/grant_a0"}, 32'(g0), 32'(eg));
      chk({tag, "/grant_a1"}, 32'(g1), 32'(eg));
    end
`endif
  endtask

  // Called at posedge+1: apply inputs, check the combinational ack, clock once,
  // then check the registered outputs.
  task automatic step(input string tag, input logic [N-1:0] r, input logic rdy,
                      input logic [N-1:0] e_ack, input logic e_v, input logic [W-1:0] e_i);
    req       = r;
    out_ready = rdy;
    #2;
    exp_ack(tag, e_ack);
    tick();
    exp_out(tag, e_v, e_i);
  endtask

  int           m_ptr, m_i, w, worst;
  logic         m_v, load, found;
  logic [N-1:0] e_ack;
  int           wait_cnt [N];

  initial begin
    rst_n     = 1'b0;
    req       = 8'hFF;
    out_ready = 1'b0;
    tick();
    #2;
    exp_out("reset", 1'b0, 3'd0);
    exp_ack("reset", '0);
    tick();

    // All requesters active: strict 0..7,0 order.
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step($sformatf("all_%0d", k), 8'hFF, 1'b1, N'(1) << (k % N), 1'b1, W'(k % N));
    end
    // ptr=1 now; grant 2 moves ptr to 3.
    step("ptr_to3", 8'h04, 1'b1, 8'h04, 1'b1, 3'd2);
    step("wrap_7a", 8'h84, 1'b1, 8'h80, 1'b1, 3'd7);
    step("wrap_2",  8'h84, 1'b1, 8'h04, 1'b1, 3'd2);
    step("wrap_7b", 8'h84, 1'b1, 8'h80, 1'b1, 3'd7);

    // ptr=0: grant 5, then stall for 4 cycles while req changes.
    step("g5", 8'h20, 1'b1, 8'h20, 1'b1, 3'd5);
    for (int k = 0; k < 4; k++) begin
      step($sformatf("stall_%0d", k), 8'h01, 1'b0, 8'h00, 1'b1, 3'd5);
    end
    step("unstall", 8'h01, 1'b1, 8'h01, 1'b1, 3'd0);

    // ptr=1: req drops; valid clears, idx and ptr hold.
    step("drop", 8'h00, 1'b1, 8'h00, 1'b0, 3'd0);
    step("ptr_held", 8'h03, 1'b1, 8'h02, 1'b1, 3'd1);
    step("g4", 8'h10, 1'b1, 8'h10, 1'b1, 3'd4);

    // Asynchronous reset between edges while a grant is held.
    req       = 8'hFF;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_out("async_rst", 1'b0, 3'd0);
    exp_ack("async_rst", '0);
    tick();
    rst_n = 1'b1;
    step("post_rst", 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0);

    // Randomised run against an independent model.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    m_ptr = 0;
    m_v   = 1'b0;
    m_i   = 0;
    worst = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      req       = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #2;
      load  = !m_v || out_ready;
      found = 1'b0;
      w     = 0;
      for (int off = 0; off < N; off++) begin
        if (!found && req[(m_ptr + off) % N]) begin
          found = 1'b1;
          w     = (m_ptr + off) % N;
        end
      end
      e_ack = (load && found) ? (N'(1) << w) : '0;
      exp_ack("rnd", e_ack);
      for (int i = 0; i < N; i++) begin
        if (!req[i]) wait_cnt[i] = 0;
      end
      if (load) begin
        if (found) begin
          m_v   = 1'b1;
          m_i   = w;
          m_ptr = (w + 1) % N;
          for (int i = 0; i < N; i++) begin
            if (i == w) begin
              wait_cnt[i] = 0;
            end else if (req[i]) begin
              wait_cnt[i]++;
              if (wait_cnt[i] > worst) worst = wait_cnt[i];
            end
          end
        end else begin
          m_v = 1'b0;
        end
      end
      tick();
      exp_out("rnd", m_v, W'(m_i));
    end
    chk("no_starve", 32'(worst <= N - 1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
